// File: rtl/id_src_decode.sv
// id_src_decode: decodes the IF/ID instruction into the ID/EX register.
// It also inserts load-use bubbles and handles EX stall, branch flush and halt.
module id_src_decode #(
   parameter int         BUB_CNT_W = 16,
   parameter logic [3:0] ZERO_REG  = 4'd0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [15:0]          id_instr,
   input  logic                 id_valid,
   input  logic                 ex_stall,
   input  logic                 flush,
   output logic                 id_stall,
   output logic                 ex_valid,
   output logic                 ex_src1sel,
   output logic [7:0]           ex_imm,
   output logic [3:0]           ex_rs_addr,
   output logic [3:0]           ex_rt_addr,
   output logic [3:0]           ex_rd_addr,
   output logic                 ex_we,
   output logic                 ex_mem_rd,
   output logic                 ex_mem_wr,
   output logic [2:0]           ex_alu_op,
   output logic                 ex_illegal,
   output logic                 halted,
   output logic [BUB_CNT_W-1:0] bubble_cnt
);
   typedef struct packed {
      logic       valid;
      logic       src1sel;
      logic [7:0] imm;
      logic [3:0] rs;
      logic [3:0] rt;
      logic [3:0] rd;
      logic       we;
      logic       mem_rd;
      logic       mem_wr;
      logic [2:0] alu_op;
      logic       illegal;
   } idex_t;
   typedef enum logic {RUN, HALTED} state_t;
   state_t               state, state_nxt;
   idex_t                q, dec, nxt;
   logic                 use_rs, use_rt, hazard;
   logic [BUB_CNT_W-1:0] cnt_nxt;
   logic [3:0]           op;
   logic [7:0]           off;
   assign op  = id_instr[15:12];
   assign off = {{4{id_instr[3]}}, id_instr[3:0]};
   always_comb begin
      dec       = '0;
      dec.valid = 1'b1;
      use_rs    = 1'b0;
      use_rt    = 1'b0;
      case (op)
         4'h0, 4'h1, 4'h2, 4'h3: begin
            dec.alu_op = op[2:0];
            dec.we     = 1'b1;
            dec.rd     = id_instr[11:8];
            dec.rs     = id_instr[7:4];
            dec.rt     = id_instr[3:0];
            use_rs     = 1'b1;
            use_rt     = 1'b1;
         end
         4'h4: begin
            dec.src1sel = 1'b1;
            dec.imm     = id_instr[7:0];
            dec.we      = 1'b1;
            dec.rd      = id_instr[11:8];
            dec.rs      = id_instr[11:8];
            use_rs      = 1'b1;
         end
         4'h5: begin
            dec.src1sel = 1'b1;
            dec.imm     = id_instr[7:0];
            dec.we      = 1'b1;
            dec.rd      = id_instr[11:8];
            dec.alu_op  = 3'b101;
         end
         4'h8: begin
            dec.src1sel = 1'b1;
            dec.imm     = off;
            dec.we      = 1'b1;
            dec.mem_rd  = 1'b1;
            dec.rd      = id_instr[11:8];
            dec.rs      = id_instr[7:4];
            use_rs      = 1'b1;
         end
         4'h9: begin
            dec.src1sel = 1'b1;
            dec.imm     = off;
            dec.mem_wr  = 1'b1;
            dec.rs      = id_instr[7:4];
            dec.rt      = id_instr[11:8];
            use_rs      = 1'b1;
            use_rt      = 1'b1;
         end
         4'hF: begin
         end
         default: dec.illegal = 1'b1;
      endcase
   end
   // Only a load still sitting in EX can be too late for the instruction in ID
   assign hazard = q.valid & q.mem_rd & (q.rd != ZERO_REG) & id_valid &
                   ((use_rs & (dec.rs == q.rd)) | (use_rt & (dec.rt == q.rd)));
   always_comb begin
      nxt       = q;
      state_nxt = state;
      cnt_nxt   = bubble_cnt;
      id_stall  = 1'b0;
      if (state == HALTED) begin
         id_stall = 1'b1;
      end else if (flush) begin
         nxt = '0;
      end else if (ex_stall) begin
         id_stall = 1'b1;
      end else if (hazard) begin
         nxt      = '0;
         id_stall = 1'b1;
         cnt_nxt  = &bubble_cnt ? bubble_cnt : bubble_cnt + 1'b1;
      end else begin
         nxt = id_valid ? dec : '0;
         if (id_valid && op == 4'hF) state_nxt = HALTED;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         q          <= '0;
         bubble_cnt <= '0;
      end else begin
         state      <= state_nxt;
         q          <= nxt;
         bubble_cnt <= cnt_nxt;
      end
   end
   assign halted     = (state == HALTED);
   assign ex_valid   = q.valid;
   assign ex_src1sel = q.src1sel;
   assign ex_imm     = q.imm;
   assign ex_rs_addr = q.rs;
   assign ex_rt_addr = q.rt;
   assign ex_rd_addr = q.rd;
   assign ex_we      = q.we;
   assign ex_mem_rd  = q.mem_rd;
   assign ex_mem_wr  = q.mem_wr;
   assign ex_alu_op  = q.alu_op;
   assign ex_illegal = q.illegal;
endmodule

// File: doc/id_src_decode.md
Name: id_src_decode

Overview:
- Decode-stage producer of the EX-stage source-select controls: src1sel, the 8-bit immediate, register addresses and write/memory enables.
- Takes the IF/ID instruction, decodes it and registers the result into the ID/EX pipeline register.
- Detects load-use hazards and inserts bubbles; handles downstream stall, branch flush and halt.
- Sits between the IF/ID register and the EX-stage source mux/ALU of the 16-bit pipeline.

Parameters:
- BUB_CNT_W, 16, width of the saturating bubble counter.
- ZERO_REG, 0, register index hard-wired to zero; never causes a hazard.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_instr  input  16  instruction from IF/ID.
- id_valid  input  1  id_instr is a real instruction.
- ex_stall  input  1  EX cannot accept; hold ID/EX register.
- flush  input  1  branch taken; squash the instruction in ID.
- id_stall  output  1  combinational; hold PC and IF/ID this cycle.
- ex_valid  output  1  ID/EX holds a live instruction.
- ex_src1sel  output  1  1 = EX src1 uses the sign-extended immediate.
- ex_imm  output  8  immediate for EX sign extension.
- ex_rs_addr  output  4  source register 1.
- ex_rt_addr  output  4  source register 2.
- ex_rd_addr  output  4  destination register.
- ex_we  output  1  register write enable.
- ex_mem_rd  output  1  load.
- ex_mem_wr  output  1  store.
- ex_alu_op  output  3  ALU function.
- ex_illegal  output  1  undefined opcode, converted to NOP.
- halted  output  1  HLT has entered EX.
- bubble_cnt  output  BUB_CNT_W  saturating count of hazard bubbles.

Behaviour:
- Fields: op = [15:12], rd = [11:8], rs = [7:4], rt = [3:0].
- op 0x0–0x3 (ADD/SUB/AND/NOR):
  - alu_op = op[2:0], src1sel = 0, we = 1; rs and rt used.
- op 0x4 ADDI:
  - rs_addr = rd, imm = [7:0], src1sel = 1, alu_op = ADD, we = 1.
- op 0x5 LLB:
  - imm = [7:0], src1sel = 1, alu_op = 3'b101 (pass), we = 1, rs_addr = 0.
- op 0x8 LW:
  - rs = base; imm = sign-extended [3:0] to 8 bits; src1sel = 1; mem_rd = 1; we = 1.
- op 0x9 SW:
  - rs = base, rt_addr = [11:8] (data), imm = sign-extended [3:0], src1sel = 1, mem_wr = 1, we = 0.
- op 0xF HLT: all enables 0; marks halt.
- Any other op:
  - All enables 0, ex_illegal = 1 registered with ex_valid = 1.
  - Unused address fields are driven 0.
- Bubble means: ex_valid = 0 and we/mem_rd/mem_wr/illegal = 0. Other fields are don't-care; the implementation drives them 0.
- Hazard (combinational): ex_valid & ex_mem_rd & ex_rd_addr != ZERO_REG & id_valid, and the ID instruction reads ex_rd_addr as rs or rt.
  - "Reads" is per-opcode. LLB, HLT and illegal read nothing.
- Priority each cycle, latency 1:
  1. rst_n low: every output 0; state RUN; bubble_cnt 0.
  2. halted: ID/EX held frozen; id_stall = 1.
  3. flush: ID/EX loads a bubble, even if ex_stall = 1. The squashed instruction is discarded; id_stall = 0; no count.
  4. ex_stall: ID/EX holds; id_stall = 1.
  5. hazard: ID/EX loads a bubble; id_stall = 1; bubble_cnt += 1, saturating at all-ones.
  6. otherwise: ID/EX loads the decode if id_valid, else a bubble.
- Hazard clears the next cycle because the load has left EX, so exactly one bubble is inserted per load-use.
- FSM states: RUN and HALTED.
  - RUN → HALTED on the edge where a valid HLT is loaded into ID/EX; halted = 1 from that edge.
  - HALTED is left only by reset.
  - flush in HALTED is ignored.
- Reset asserted mid-operation clears everything asynchronously. No partial state survives.

Test Plan:
- Reset then id_instr = 0x4_3_F0 (ADDI r3, 0xF0), id_valid = 1 -> next cycle: ex_valid = 1, src1sel = 1, ex_imm = 0xF0, rs = rd = 3, we = 1.
- LW r5, [r2 + 0xC], then ADD r1, r5, r4 -> one cycle with id_stall = 1 and an EX bubble; LW offset ex_imm = 0xFC; bubble_cnt = 1; ADD enters EX the cycle after.
- LW r0, then ADD r1, r0, r0 -> no stall; bubble_cnt stays 0.
- ex_stall held 3 cycles with ADD in ID/EX -> EX outputs unchanged, id_stall = 1 throughout; flush during the stall -> bubble loaded that cycle.
- op 0xB -> ex_valid = 1, ex_illegal = 1, we = mem_rd = mem_wr = 0.
- HLT then ADD: halted = 1 one cycle after HLT is accepted; EX frozen and id_stall = 1 afterwards; flush has no effect; rst_n low clears halted; a preloaded bubble_cnt of 0xFFFF plus one more hazard stays at 0xFFFF.
